uart_core: RTL
==============

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 115_200, line rate in bit/s.
REQ-003 SHALL provide parameter OVERSAMPLE, default 16, RX sample ticks per bit (even, 8..32).
REQ-004 SHALL provide parameter DATA_BITS, default 8, payload bits per frame (5..8).
REQ-005 SHALL provide parameter STOP_BITS, default 1, stop bits sent and checked (1 or 2).
REQ-006 SHALL provide parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd); used only under UART_PARITY_EN.
REQ-007 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, asynchronous and active-low.
REQ-008 SHALL have ports: rxd  in  1  serial input (asynchronous); txd  out  1  serial output, idle high.
REQ-009 SHALL have ports: tx_data  in  DATA_BITS  byte to send; tx_valid  in  1; tx_ready  out  1; tx_busy  out  1  frame in flight.
REQ-010 SHALL have ports: rx_data  out  DATA_BITS; rx_valid  out  1; rx_ready  in  1.
REQ-011 SHALL have ports: rx_frame_err, rx_parity_err  out  1  qualify rx_data while rx_valid; rx_overrun  out  1  one-cycle pulse.

Function
REQ-012 SHALL derive tick divisor DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), minimum 1, at elaboration; bit period BIT = DIV*OVERSAMPLE clk cycles; no derived clocks, enables only.
REQ-013 SHALL use frame format start(0), DATA_BITS LSB first, optional parity, STOP_BITS stop(1).
REQ-014 TX SHALL accept on clk edge with tx_valid && tx_ready; tx_ready low from the following cycle until the last stop bit ends.
REQ-015 TX SHALL drive start bit starting the cycle after acceptance; each bit lasts exactly BIT cycles; tx_ready rises in the final cycle of the last stop bit so back-to-back frames have zero idle gap.
REQ-016 TX states: IDLE, START, DATA, PARITY, STOP; PARITY skipped when UART_PARITY_EN undefined.
REQ-017 RX SHALL pass rxd through a 2-flop synchroniser, then detect falling edge in IDLE.
REQ-018 RX SHALL recheck line at tick OVERSAMPLE/2 of start bit; if high, false start, return to IDLE with no output.
REQ-019 RX SHALL sample every later bit by 2-of-3 majority at ticks OVERSAMPLE/2-1, /2, /2+1.
REQ-020 RX SHALL check only the first stop bit; low stop bit sets rx_frame_err with the frame, and RX waits for line high before re-arming.
REQ-021 RX SHALL present rx_data/flags with rx_valid one cycle after the first stop-bit mid-sample; held stable until rx_valid && rx_ready.
REQ-022 If a frame completes while rx_valid && !rx_ready, new frame SHALL be discarded, held data kept, rx_overrun pulsed one cycle.
REQ-023 Simultaneous frame completion and consumption SHALL load the new frame (no overrun).
REQ-024 RX states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-025 TX and RX SHALL run fully independently (full duplex).

Reset
REQ-026 On rst_n low, asynchronously: txd=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, all error outputs 0, both FSMs IDLE, counters 0, synchroniser flops 1.
REQ-027 Reset mid-frame SHALL abort both directions; no partial frame delivered after release; TX line high within the reset cycle.

Configuration
REQ-028 Macro UART_PARITY_EN defined: parity bit sent after data (XOR of data, inverted if PARITY_ODD); mismatch sets rx_parity_err.
REQ-029 UART_PARITY_EN undefined: no parity bit in either direction, rx_parity_err tied 0, no parity logic synthesised.

Structure
REQ-030 Package uart_pkg SHALL hold tx/rx state enum typedefs and the DIV/BIT calculation functions.
REQ-031 Sub-module uart_rx SHALL hold synchroniser, RX FSM and output register; TX FSM inline in uart_core.

Verification (CLK_HZ=1_600_000, BAUD=100_000, OVERSAMPLE=16 -> DIV=1, BIT=16)
REQ-032 tx_data=0x55 accepted at cycle 0 -> txd low cycles 1-16, then 1,0,1,0,1,0,1,0 per 16 cycles, high 145-160, tx_ready high at 160.
REQ-033 Drive rxd frame 0xA3 with 3-cycle glitch mid-bit2 -> rx_valid with rx_data=0xA3, no errors.
REQ-034 rxd low pulse 6 cycles -> false start, no rx_valid; following frame 0x0F received correctly.
REQ-035 Frame 0x12 with stop bit low -> rx_data=0x12, rx_frame_err=1; next frame after line high clean.
REQ-036 Two frames 0x01, 0x02 with rx_ready=0 -> rx_data stays 0x01, rx_overrun pulses once; under UART_PARITY_EN even, frame 0x07 with parity bit 0 -> rx_parity_err=1.
REQ-037 Assert rst_n low mid-TX-frame -> txd=1 immediately, tx_ready=1 after release, next tx_data=0xC3 sent intact.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: FSM state types and baud divisor arithmetic shared by uart_core and uart_rx.
package uart_pkg;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_e;
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int d;
    d = (clk_hz + baud * os / 2) / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction
  function automatic int calc_bit(input int clk_hz, input int baud, input int os);
    return calc_div(clk_hz, baud, os) * os;
  endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: rxd synchroniser, oversampling receive FSM and held output register.
// Parity check exists only when UART_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS = 8
`ifdef UART_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam rx_state_e RX_AFTER_DATA =
`ifdef UART_PARITY_EN
    RX_PARITY;
`else
    RX_STOP;
`endif
  rx_state_e            st_q;
  logic [1:0]           sync_q;
  logic                 prev_q;
  logic [DW-1:0]        div_q;
  logic [TW-1:0]        tick_q;
  logic [1:0]           smp_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] sh_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ovr_q;
  logic                 line;
  logic                 tick;
  logic                 mid;
  logic                 dec;
  logic                 maj;
`ifdef UART_PARITY_EN
  logic                 pbad_q;
  logic                 perr_q;
  assign rx_parity_err = perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif
  assign line = sync_q[1];
  assign tick = div_q == DW'(DIV - 1);
  assign mid  = tick && tick_q == TW'(OVERSAMPLE / 2);
  assign dec  = tick && tick_q == TW'(OVERSAMPLE / 2 + 1);
  // smp_q holds the samples from ticks OS/2-1 and OS/2; line is the third vote
  assign maj  = (smp_q[1] & smp_q[0]) | (smp_q[1] & line) | (smp_q[0] & line);
  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= RX_IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      div_q   <= '0;
      tick_q  <= '0;
      smp_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_PARITY_EN
      pbad_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[0], rxd};
      prev_q <= line;
      ovr_q  <= 1'b0;
      if (st_q == RX_IDLE) begin
        div_q  <= '0;
        tick_q <= '0;
      end else if (tick) begin
        div_q  <= '0;
        tick_q <= (tick_q == TW'(OVERSAMPLE - 1)) ? '0 : tick_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (tick && (tick_q == TW'(OVERSAMPLE / 2 - 1) || tick_q == TW'(OVERSAMPLE / 2)))
        smp_q <= {smp_q[0], line};
      if (valid_q && rx_ready)
        valid_q <= 1'b0;
      case (st_q)
        RX_IDLE: if (prev_q && !line) st_q <= RX_START;
        RX_START: begin
          if (mid && line)
            st_q <= RX_IDLE;
          else if (tick && tick_q == TW'(OVERSAMPLE - 1)) begin
            st_q  <= RX_DATA;
            idx_q <= '0;
          end
        end
        RX_DATA: if (dec) begin
          sh_q  <= {maj, sh_q[DATA_BITS-1:1]};
          idx_q <= idx_q + 1'b1;
          if (idx_q == 3'(DATA_BITS - 1))
            st_q <= RX_AFTER_DATA;
        end
`ifdef UART_PARITY_EN
        RX_PARITY: if (dec) begin
          pbad_q <= maj ^ (^sh_q) ^ PARITY_ODD;
          st_q   <= RX_STOP;
        end
`endif
        RX_STOP: if (dec) begin
          st_q <= maj ? RX_IDLE : RX_WAIT_HIGH;
          // a held, unconsumed frame wins over the new one
          if (valid_q && !rx_ready)
            ovr_q <= 1'b1;
          else begin
            valid_q <= 1'b1;
            data_q  <= sh_q;
            ferr_q  <= !maj;
`ifdef UART_PARITY_EN
            perr_q  <= pbad_q;
`endif
          end
        end
        RX_WAIT_HIGH: if (line) st_q <= RX_IDLE;
        default: st_q <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex UART, TX FSM inline, receiver in uart_rx.
// Define UART_PARITY_EN to add a parity bit in both directions.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic                 txd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int BIT = calc_bit(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int CW  = $clog2(BIT);
  localparam tx_state_e TX_AFTER_DATA =
`ifdef UART_PARITY_EN
    TX_PARITY;
`else
    TX_STOP;
`endif
  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 ||
      PARITY_ODD > 1 || OVERSAMPLE < 8 || OVERSAMPLE > 32 || OVERSAMPLE % 2 != 0) begin : g_bad_cfg
    $error("uart_core: unsupported parameter set");
  end
  tx_state_e            tx_st_q;
  logic [CW-1:0]        tx_cnt_q;
  logic [2:0]           tx_idx_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 txd_q;
  logic                 tx_ready_q;
  logic                 tx_busy_q;
  logic                 tx_acc;
  logic                 bit_end;
  logic                 last_stop;
  logic                 tx_post;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
  assign tx_post = tx_par_q;
`else
  assign tx_post = 1'b1;
`endif
  assign tx_acc    = tx_valid && tx_ready_q;
  assign bit_end   = tx_cnt_q == CW'(BIT - 1);
  assign last_stop = tx_idx_q == 3'(STOP_BITS - 1);
  assign txd       = txd_q;
  assign tx_ready  = tx_ready_q;
  assign tx_busy   = tx_busy_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q    <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_cnt_q <= (tx_st_q == TX_IDLE || bit_end) ? '0 : tx_cnt_q + 1'b1;
      case (tx_st_q)
        TX_START: if (bit_end) begin
          tx_st_q  <= TX_DATA;
          txd_q    <= tx_sh_q[0];
          tx_sh_q  <= tx_sh_q >> 1;
          tx_idx_q <= '0;
        end
        TX_DATA: if (bit_end) begin
          txd_q    <= tx_sh_q[0];
          tx_sh_q  <= tx_sh_q >> 1;
          tx_idx_q <= tx_idx_q + 1'b1;
          if (tx_idx_q == 3'(DATA_BITS - 1)) begin
            tx_st_q  <= TX_AFTER_DATA;
            txd_q    <= tx_post;
            tx_idx_q <= '0;
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: if (bit_end) begin
          tx_st_q  <= TX_STOP;
          txd_q    <= 1'b1;
          tx_idx_q <= '0;
        end
`endif
        TX_STOP: begin
          // ready one cycle early so a waiting frame follows with no idle gap
          if (last_stop && tx_cnt_q == CW'(BIT - 2))
            tx_ready_q <= 1'b1;
          if (bit_end) begin
            tx_idx_q <= tx_idx_q + 1'b1;
            if (last_stop) begin
              tx_st_q   <= TX_IDLE;
              tx_busy_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
      if (tx_acc) begin
        tx_st_q    <= TX_START;
        txd_q      <= 1'b0;
        tx_ready_q <= 1'b0;
        tx_busy_q  <= 1'b1;
        tx_sh_q    <= tx_data;
        tx_idx_q   <= '0;
`ifdef UART_PARITY_EN
        tx_par_q   <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
      end
    end
  end
  uart_rx #(
    .DIV(DIV),
    .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS(DATA_BITS)
`ifdef UART_PARITY_EN
    , .PARITY_ODD(PARITY_ODD != 0)
`endif
  ) u_rx (
    .clk(clk),
    .rst_n(rst_n),
    .rxd(rxd),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_overrun(rx_overrun)
  );
endmodule
